// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared constants and types for the SCCB register sequencer
package sccb_pkg;

    localparam logic [5:0] CMD_WR   = 6'h01;
    localparam logic [5:0] CMD_STA  = 6'h02;
    localparam logic [5:0] CMD_RD   = 6'h04;
    localparam logic [5:0] CMD_STO  = 6'h08;
    localparam logic [5:0] CMD_ACK  = 6'h10;
    localparam logic [5:0] CMD_NACK = 6'h20;

    localparam logic [6:0] SCCB_DEV_ADDR = 7'h3C;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_t;

endpackage

// File: rtl/sccb_reg_ctrl_if.sv
// rtl/sccb_reg_ctrl_if.sv - request-side and bit-shifter-side bundles for the SCCB sequencer
interface sccb_req_if;
    logic        wr_req;
    logic        rd_req;
    logic [15:0] reg_addr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic        ack_err;

    modport master (output wr_req, rd_req, reg_addr, wr_data,
                    input  rd_data, busy, done, ack_err);
    modport slave  (input  wr_req, rd_req, reg_addr, wr_data,
                    output rd_data, busy, done, ack_err);
endinterface

interface sccb_i2c_if;
    logic [5:0] Cmd;
    logic       Go;
    logic [7:0] Tx_DATA;
    logic [7:0] Rx_DATA;
    logic       Trans_Done;
    logic       ack_o;

    modport master (output Cmd, Go, Tx_DATA,
                    input  Rx_DATA, Trans_Done, ack_o);
    modport slave  (input  Cmd, Go, Tx_DATA,
                    output Rx_DATA, Trans_Done, ack_o);
endinterface

// File: rtl/sccb_step_rom.sv
// rtl/sccb_step_rom.sv - byte-level command table for SCCB register writes and reads
module sccb_step_rom
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = SCCB_DEV_ADDR
) (
    input  op_t         op,
    input  logic [2:0]  step,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  wr_data,
    output logic [5:0]  cmd,
    output logic [7:0]  tx,
    output logic        last
);

    always_comb begin
        cmd  = '0;
        tx   = '0;
        last = 1'b0;
        case (step)
            3'd0: begin
                cmd = CMD_STA | CMD_WR;
                tx  = {DEV_ADDR, 1'b0};
            end
            3'd1: begin
                cmd = CMD_WR;
                tx  = reg_addr[15:8];
            end
            // Reads close the address phase with a STOP before the restart
            3'd2: begin
                cmd = (op == OP_RD) ? (CMD_WR | CMD_STO) : CMD_WR;
                tx  = reg_addr[7:0];
            end
            3'd3: begin
                if (op == OP_RD) begin
                    cmd = CMD_STA | CMD_WR;
                    tx  = {DEV_ADDR, 1'b1};
                end else begin
                    cmd  = CMD_WR | CMD_STO;
                    tx   = wr_data;
                    last = 1'b1;
                end
            end
            3'd4: begin
                cmd  = CMD_RD | CMD_NACK | CMD_STO;
                last = 1'b1;
            end
            default: last = 1'b1;
        endcase
    end

endmodule

// File: rtl/sccb_reg_ctrl.sv
// rtl/sccb_reg_ctrl.sv - sequences one SCCB register write/read into i2c_bit_shift steps
module sccb_reg_ctrl
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = SCCB_DEV_ADDR,
    parameter bit         ADDR_16BIT = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst_p,
    sccb_req_if.slave   req,
    sccb_i2c_if.master  i2c
);

    state_t      state, state_n;
    op_t         op_q;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic [2:0]  step_q;
    logic        err_q;
    logic [5:0]  cmd_q;
    logic [7:0]  tx_q;
    logic        last_q;
    logic [7:0]  rd_data_q;

    logic        accept;
    op_t         req_op;
    logic [2:0]  step_adv;
    op_t         rom_op;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [2:0]  rom_step;
    logic [5:0]  rom_cmd;
    logic [7:0]  rom_tx;
    logic        rom_last;

    assign accept   = (state == ST_IDLE) && (req.wr_req || req.rd_req);
    assign req_op   = req.wr_req ? OP_WR : OP_RD;
    // 8-bit register addresses skip the high address byte
    assign step_adv = (step_q == 3'd0 && ADDR_16BIT == 1'b0) ? 3'd2 : step_q + 3'd1;

    // The table is addressed with the values the step will use, so Cmd/Tx_DATA
    // can be registered in the same edge that enters ISSUE.
    assign rom_op   = accept ? req_op       : op_q;
    assign rom_addr = accept ? req.reg_addr : addr_q;
    assign rom_data = accept ? req.wr_data  : data_q;
    assign rom_step = accept ? 3'd0         : step_adv;

    sccb_step_rom #(.DEV_ADDR(DEV_ADDR)) u_rom (
        .op       (rom_op),
        .step     (rom_step),
        .reg_addr (rom_addr),
        .wr_data  (rom_data),
        .cmd      (rom_cmd),
        .tx       (rom_tx),
        .last     (rom_last)
    );

    always_ff @(posedge Clk or posedge Rst_p) begin
        if (Rst_p) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (accept) state_n = ST_ISSUE;
            ST_ISSUE:  state_n = ST_WAIT;
            ST_WAIT:   if (i2c.Trans_Done) state_n = ST_NEXT;
            ST_NEXT:   state_n = last_q ? ST_FINISH : ST_ISSUE;
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        i2c.Go      = (state == ST_ISSUE);
        i2c.Cmd     = cmd_q;
        i2c.Tx_DATA = tx_q;
        req.busy    = (state != ST_IDLE);
        req.done    = (state == ST_FINISH);
        req.ack_err = (state == ST_FINISH) && err_q;
        req.rd_data = rd_data_q;
    end

    always_ff @(posedge Clk or posedge Rst_p) begin
        if (Rst_p) begin
            op_q      <= OP_WR;
            addr_q    <= '0;
            data_q    <= '0;
            step_q    <= '0;
            err_q     <= 1'b0;
            cmd_q     <= '0;
            tx_q      <= '0;
            last_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= req_op;
                addr_q <= req.reg_addr;
                data_q <= req.wr_data;
                step_q <= 3'd0;
                err_q  <= 1'b0;
            end
            if (state_n == ST_ISSUE) begin
                cmd_q  <= rom_cmd;
                tx_q   <= rom_tx;
                last_q <= rom_last;
            end
            if (state == ST_NEXT) begin
                if (!last_q) step_q <= step_adv;
                if ((cmd_q & CMD_WR) != 6'd0) err_q <= err_q | i2c.ack_o;
                // The RD step is always the final one, so the result is visible with done
                if ((cmd_q & CMD_RD) != 6'd0) rd_data_q <= i2c.Rx_DATA;
            end
        end
    end

endmodule
